// File: rtl/tdp_march_if.sv
// Bundle between the march controller, the test top-level start/status logic and the
// dual-port RAM under test.
interface tdp_march_if #(
    parameter int DATA_W = 512,
    parameter int ADDR_W = 4,
    parameter int ERR_W  = 8
);
    logic              start;
    logic              weA;
    logic [ADDR_W-1:0] addrA;
    logic [DATA_W-1:0] dinA;
    logic [DATA_W-1:0] doutA;
    logic              weB;
    logic [ADDR_W-1:0] addrB;
    logic [DATA_W-1:0] dinB;
    logic [DATA_W-1:0] doutB;
    logic              busy;
    logic              done;
    logic              pass;
    logic [ERR_W-1:0]  err_cnt;
    logic [ADDR_W-1:0] first_err_addr;
    logic              first_err_port;

    modport master (
        input  start, doutA, doutB,
        output weA, addrA, dinA, weB, addrB, dinB,
        output busy, done, pass, err_cnt, first_err_addr, first_err_port
    );

    modport slave (
        output start, doutA, doutB,
        input  weA, addrA, dinA, weB, addrB, dinB,
        input  busy, done, pass, err_cnt, first_err_addr, first_err_port
    );
endinterface

// File: rtl/tdp_march_ctrl.sv
// March-test initiator for a true-dual-port RAM: background write on A, read on B,
// inverse write on B, read on A, with whole-word compare and first-failure logging.
module tdp_march_ctrl #(
    parameter int DATA_W = 512,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 10,
    parameter int ERR_W  = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    tdp_march_if.master mif_io
);
    // One extra count value is needed for the drain cycle of each read phase.
    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_DRAIN = CNT_W'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_W_BG  = 3'd1,
        S_R_BG  = 3'd2,
        S_W_INV = 3'd3,
        S_R_INV = 3'd4,
        S_DONE  = 3'd5
    } state_e;

    function automatic logic [DATA_W-1:0] pattern_word(input logic [ADDR_W-1:0] a);
        return {(DATA_W/4){4'b0101}} ^ DATA_W'(a);
    endfunction

    // Inverse phases walk the array downwards.
    function automatic logic [ADDR_W-1:0] phase_addr(input state_e st, input logic [CNT_W-1:0] cnt);
        logic [CNT_W-1:0] a;
        if (st == S_W_INV || st == S_R_INV) begin
            a = CNT_LAST - cnt;
        end else begin
            a = cnt;
        end
        return a[ADDR_W-1:0];
    endfunction

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              clear_s;
    logic [ADDR_W-1:0] addr_s;

    logic              weA_q, weA_d, weB_q, weB_d;
    logic [ADDR_W-1:0] addrA_q, addrA_d, addrB_q, addrB_d;
    logic [DATA_W-1:0] dinA_q, dinA_d, dinB_q, dinB_d;
    logic              busy_q, busy_d, done_q, done_d, pass_q, pass_d;

    logic              tag_vld_q, tag_vld_d;
    logic [ADDR_W-1:0] tag_addr_q, tag_addr_d;
    logic              tag_port_q, tag_port_d;
    logic [DATA_W-1:0] exp_s, rd_s;
    logic              mismatch_s;

    logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;
    logic [ADDR_W-1:0] fe_addr_q, fe_addr_d;
    logic              fe_port_q, fe_port_d;

    // Phase sequencing and per-phase cycle counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clear_s = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (mif_io.start) begin
                    state_d = S_W_BG;
                    cnt_d   = {CNT_W{1'b0}};
                    clear_s = 1'b1;
                end else begin
                    cnt_d   = {CNT_W{1'b0}};
                end
            end
            S_W_BG: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = S_R_BG;
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            S_R_BG: begin
                if (cnt_q == CNT_DRAIN) begin
                    state_d = S_W_INV;
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            S_W_INV: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = S_R_INV;
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            S_R_INV: begin
                if (cnt_q == CNT_DRAIN) begin
                    state_d = S_DONE;
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = {CNT_W{1'b0}};
            end
        endcase
    end

    // RAM port drive, decoded from the next state so the registered outputs line up with it.
    always_comb begin
        weA_d   = 1'b0;
        addrA_d = {ADDR_W{1'b0}};
        dinA_d  = {DATA_W{1'b0}};
        weB_d   = 1'b0;
        addrB_d = {ADDR_W{1'b0}};
        dinB_d  = {DATA_W{1'b0}};
        addr_s  = phase_addr(state_d, cnt_d);
        case (state_d)
            S_W_BG: begin
                weA_d   = 1'b1;
                addrA_d = addr_s;
                dinA_d  = pattern_word(addr_s);
            end
            S_R_BG: begin
                if (cnt_d != CNT_DRAIN) begin
                    addrB_d = addr_s;
                end else begin
                    addrB_d = {ADDR_W{1'b0}};
                end
            end
            S_W_INV: begin
                weB_d   = 1'b1;
                addrB_d = addr_s;
                dinB_d  = ~pattern_word(addr_s);
            end
            S_R_INV: begin
                if (cnt_d != CNT_DRAIN) begin
                    addrA_d = addr_s;
                end else begin
                    addrA_d = {ADDR_W{1'b0}};
                end
            end
            default: begin
                weA_d = 1'b0;
            end
        endcase
        busy_d = (state_d == S_W_BG) || (state_d == S_R_BG) ||
                 (state_d == S_W_INV) || (state_d == S_R_INV);
        done_d = (state_d == S_DONE);
    end

    // Read tag tracks the address issued this cycle; its data is checked one cycle later.
    always_comb begin
        tag_vld_d  = ((state_q == S_R_BG) || (state_q == S_R_INV)) && (cnt_q != CNT_DRAIN);
        tag_addr_d = phase_addr(state_q, cnt_q);
        tag_port_d = (state_q == S_R_BG);
        if (tag_port_q) begin
            exp_s = pattern_word(tag_addr_q);
            rd_s  = mif_io.doutB;
        end else begin
            exp_s = ~pattern_word(tag_addr_q);
            rd_s  = mif_io.doutA;
        end
        mismatch_s = tag_vld_q && (rd_s != exp_s);
    end

    // Error logging; the first-failure fields latch while the count is still zero.
    always_comb begin
        err_cnt_d = err_cnt_q;
        fe_addr_d = fe_addr_q;
        fe_port_d = fe_port_q;
        if (clear_s) begin
            err_cnt_d = {ERR_W{1'b0}};
            fe_addr_d = {ADDR_W{1'b0}};
            fe_port_d = 1'b0;
        end else if (mismatch_s) begin
            if (err_cnt_q == {ERR_W{1'b0}}) begin
                fe_addr_d = tag_addr_q;
                fe_port_d = tag_port_q;
            end else begin
                fe_addr_d = fe_addr_q;
            end
            if (err_cnt_q != {ERR_W{1'b1}}) begin
                err_cnt_d = err_cnt_q + ERR_W'(1);
            end else begin
                err_cnt_d = err_cnt_q;
            end
        end else begin
            err_cnt_d = err_cnt_q;
        end
        pass_d = (state_d == S_DONE) && (err_cnt_d == {ERR_W{1'b0}});
    end

    // State, pipeline and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= {CNT_W{1'b0}};
            weA_q      <= 1'b0;
            addrA_q    <= {ADDR_W{1'b0}};
            dinA_q     <= {DATA_W{1'b0}};
            weB_q      <= 1'b0;
            addrB_q    <= {ADDR_W{1'b0}};
            dinB_q     <= {DATA_W{1'b0}};
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            tag_vld_q  <= 1'b0;
            tag_addr_q <= {ADDR_W{1'b0}};
            tag_port_q <= 1'b0;
            err_cnt_q  <= {ERR_W{1'b0}};
            fe_addr_q  <= {ADDR_W{1'b0}};
            fe_port_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            weA_q      <= weA_d;
            addrA_q    <= addrA_d;
            dinA_q     <= dinA_d;
            weB_q      <= weB_d;
            addrB_q    <= addrB_d;
            dinB_q     <= dinB_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            tag_vld_q  <= tag_vld_d;
            tag_addr_q <= tag_addr_d;
            tag_port_q <= tag_port_d;
            err_cnt_q  <= err_cnt_d;
            fe_addr_q  <= fe_addr_d;
            fe_port_q  <= fe_port_d;
        end
    end

    assign mif_io.weA            = weA_q;
    assign mif_io.addrA          = addrA_q;
    assign mif_io.dinA           = dinA_q;
    assign mif_io.weB            = weB_q;
    assign mif_io.addrB          = addrB_q;
    assign mif_io.dinB           = dinB_q;
    assign mif_io.busy           = busy_q;
    assign mif_io.done           = done_q;
    assign mif_io.pass           = pass_q;
    assign mif_io.err_cnt        = err_cnt_q;
    assign mif_io.first_err_addr = fe_addr_q;
    assign mif_io.first_err_port = fe_port_q;
endmodule

// File: doc/tdp_march_ctrl.md
Name: tdp_march_ctrl

Overview:
- March-test initiator for the true-dual-port RAM macros in the memory test suite (registered read address, combinational read data).
- Drives both RAM ports from one clock: writes a background pattern, reads it back, writes the inverse, reads that back.
- Exercises write and read on each port, compares every read word, and reports pass/fail, error count and first failing location.
- Sits between the test top-level start/status logic and the RAM under test.

Parameters:
DATA_W, 512, RAM word width.
ADDR_W, 4, RAM address width.
DEPTH, 10, number of words tested (addresses 0..DEPTH-1); DEPTH <= 2**ADDR_W.
ERR_W, 8, error counter width.

Ports:
clk  input  1  single clock, drives both RAM ports (clkA = clkB = clk at top level).
rst_n  input  1  asynchronous active-low reset.
start  input  1  one-cycle pulse; begins a test when idle.
weA  output  1  RAM port A write enable.
addrA  output  ADDR_W  RAM port A address.
dinA  output  DATA_W  RAM port A write data.
doutA  input  DATA_W  RAM port A read data.
weB  output  1  RAM port B write enable.
addrB  output  ADDR_W  RAM port B address.
dinB  output  DATA_W  RAM port B write data.
doutB  input  DATA_W  RAM port B read data.
busy  output  1  test in progress.
done  output  1  test finished; held until next start or reset.
pass  output  1  valid while done=1; 1 when err_cnt==0.
err_cnt  output  ERR_W  mismatching words, saturating at 2**ERR_W-1.
first_err_addr  output  ADDR_W  address of first chronological mismatch.
first_err_port  output  1  port of first mismatch: 0 = A, 1 = B.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset: state IDLE. All outputs are 0: we*, addr*, din*, busy, done, pass, err_cnt, first_err_*. Reset asserted mid-test aborts immediately; no further writes are issued.
- Data pattern: BG = 4'b0101 replicated to DATA_W.
  - D(i) = BG XOR zero-extended i.
  - Inverse word is ~D(i).
- States:
  - IDLE -> W_BG on start. start is ignored when busy=1; in DONE it restarts the test.
  - W_BG: port A writes D(i), i ascending 0..DEPTH-1, one word per cycle (DEPTH cycles).
  - R_BG: port B reads, i ascending, expects D(i) (DEPTH+1 cycles).
  - W_INV: port B writes ~D(i), i descending DEPTH-1..0 (DEPTH cycles).
  - R_INV: port A reads, i descending, expects ~D(i) (DEPTH+1 cycles).
  - DONE: busy=0, done=1, pass = (err_cnt==0).
- Total busy time: 4*DEPTH+2 cycles. busy rises at the edge where start is sampled and falls at entry to DONE. For DEPTH=10, busy is high for 42 cycles.
- Idle port outputs: the port not active in a phase drives we=0, addr=0, din=0. Same in IDLE and DONE. Ports A and B are never active in the same cycle, so there are no address collisions.
- Read latency:
  - Address i driven in cycle t is registered by the RAM at the end of t.
  - dout is valid during t+1 and is sampled and compared at the end of t+1.
  - The extra (+1) read-phase cycle is a drain cycle: no new address (addr=0, we=0), compares the last issued address only.
- Expected-data/address pipeline: one register stage, tagged valid only for real read cycles. No compare occurs on the first cycle of a read phase.
- Error logging:
  - Each mismatching word increments err_cnt by 1, whole-word compare, saturating.
  - first_err_addr/port are captured only on the first mismatch since start.
- On start: err_cnt, first_err_*, done and pass are cleared.

Test Plan:
- Fault-free behavioural RAM, DEPTH=10: start pulse -> busy high 42 cycles; done=1, pass=1, err_cnt=0; weA high exactly 10 cycles; weB high exactly 10 cycles.
- RAM model with storage word 5 bit 0 stuck-at-0 -> D(5) bit0=0, so R_BG passes; R_INV fails -> err_cnt=1, first_err_addr=5, first_err_port=0, pass=0.
- Port-B read path bit 7 stuck-at-1 (BG bit7=0) -> all 10 R_BG reads fail, R_INV passes -> err_cnt=10, first_err_addr=0, first_err_port=1.
- Address alias fault: writes to address 7 also write address 6 -> W_BG leaves word 6 = D(7) -> R_BG reads word 6 as D(7), fails -> err_cnt>=1, first_err_addr=6, first_err_port=1.
- start re-pulsed at cycle 10 while busy -> ignored, completion still at cycle 42. rst_n low at cycle 20 -> all outputs 0 within the reset assertion, weA/weB low. Subsequent start -> full clean run, pass=1.
- ERR_W=3, RAM returns all-zeros on both ports -> 20 mismatches, err_cnt saturates at 7, first_err_addr=0, first_err_port=1.
